// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder: defaults, FSM encoding
// and counter sizing.
package systolic_pkg;

  localparam int DW_DEF    = 32;
  localparam int N_DEF     = 3;
  localparam int DRAIN_DEF = 4;
  localparam int FEED_LEN  = 2 * N_DEF - 1;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One counter serves both the feed index and the drain countdown.
  function automatic int cnt_width(input int n, input int drain);
    int m;
    m = (2 * n - 1 > drain) ? 2 * n - 1 : drain;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/skew_select.sv
// Picks the skewed edge operand for one array lane: vals[t-LANE] when that
// index lies inside the buffered vector, zero otherwise.
module skew_select #(
  parameter int DW   = 32,
  parameter int N    = 3,
  parameter int LANE = 0,
  parameter int CW   = 3
) (
  input  logic [CW-1:0]   t,
  input  logic [N*DW-1:0] vals,
  output logic [DW-1:0]   sel
);

  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(t) == LANE + k) sel = vals[k*DW +: DW];
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Buffers one A and one B matrix, then clears the systolic array and streams
// skewed operands onto its row and column edges, followed by a drain window.
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int N     = N_DEF,
  parameter int DRAIN = DRAIN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a_col,
  input  logic [N*DW-1:0] in_b_row,
  output logic            arr_clr,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out,
  output logic [DW-1:0]   c_out,
  output logic [DW-1:0]   d_out,
  output logic [DW-1:0]   e_out,
  output logic [DW-1:0]   f_out,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state
);

  localparam int             FLEN       = 2 * N - 1;
  localparam int             CW         = cnt_width(N, DRAIN);
  localparam logic [CW-1:0]  FEED_LAST  = CW'(FLEN - 1);
  localparam logic [CW-1:0]  DRAIN_LAST = CW'(DRAIN - 1);
  localparam logic [1:0]     BEAT_LAST  = 2'(N - 1);

  state_t          state, state_n;
  logic [1:0]      beat, beat_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            load_fire;

  // a_buf[i] holds row i of A, b_buf[j] holds column j of B; slot k at [k*DW +: DW].
  logic [N*DW-1:0] a_buf [N];
  logic [N*DW-1:0] b_buf [N];
  logic [DW-1:0]   row_sel [N];
  logic [DW-1:0]   col_sel [N];
  logic [DW-1:0]   row_q [N];
  logic [DW-1:0]   col_q [N];

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready is a register and never looks at in_valid.
  assign load_fire = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    beat_n  = beat;
    cnt_n   = cnt;
    case (state)
      ST_LOAD: begin
        if (load_fire) begin
          if (beat == BEAT_LAST) begin
            state_n = ST_CLEAR;
            beat_n  = '0;
          end else begin
            beat_n = beat + 2'd1;
          end
        end
      end
      ST_CLEAR: begin
        state_n = ST_FEED;
        cnt_n   = '0;
      end
      ST_FEED: begin
        if (cnt == FEED_LAST) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_n = ST_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DONE: state_n = ST_LOAD;
      default: state_n = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
      beat  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else if (load_fire) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i][int'(beat)*DW +: DW] <= in_a_col[i*DW +: DW];
        b_buf[i][int'(beat)*DW +: DW] <= in_b_row[i*DW +: DW];
      end
    end
  end

  // Selection runs on the next feed index so the registered operand lands in its FEED cycle.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_select #(.DW(DW), .N(N), .LANE(i), .CW(CW)) u_row (
      .t    (cnt_n),
      .vals (a_buf[i]),
      .sel  (row_sel[i])
    );
    skew_select #(.DW(DW), .N(N), .LANE(i), .CW(CW)) u_col (
      .t    (cnt_n),
      .vals (b_buf[i]),
      .sel  (col_sel[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      arr_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      in_ready <= (state_n == ST_LOAD);
      arr_clr  <= (state_n == ST_CLEAR);
      busy     <= (state_n != ST_LOAD);
      done     <= (state_n == ST_DONE);
      for (int i = 0; i < N; i++) begin
        row_q[i] <= (state_n == ST_FEED) ? row_sel[i] : '0;
        col_q[i] <= (state_n == ST_FEED) ? col_sel[i] : '0;
      end
    end
  end

  assign a_out = row_q[0];
  assign b_out = row_q[1];
  assign c_out = row_q[2];
  assign d_out = col_q[0];
  assign e_out = col_q[1];
  assign f_out = col_q[2];

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder: table-driven jobs, a
// per-cycle stream model, a bench-side array accumulator and random jobs.
module tb_systolic_operand_feeder;
  import systolic_pkg::*;

  localparam int DW  = 32;
  localparam int W   = 4 + 6 * DW;
  localparam int WIN = 11;

  typedef logic [DW-1:0] mat_t [3][3];
  typedef struct {
    mat_t       a;
    mat_t       b;
    logic [7:0] pat;
    logic       hold;
  } job_t;
  typedef struct {
    logic [DW-1:0] op [6];
  } feed_vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [3*DW-1:0] in_a_col;
  logic [3*DW-1:0] in_b_row;
  logic            arr_clr, busy, done;
  logic [DW-1:0]   a_out, b_out, c_out, d_out, e_out, f_out;
  logic [2:0]      dbg_state;
  logic [W-1:0]    act_vec;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];
  logic [DW-1:0] log_op [5][6];
  longint acc [3][3];
  logic clr_seen;

  job_t      jobs [4];
  feed_vec_t feed_tbl [5];

  systolic_operand_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a_col  (in_a_col),
    .in_b_row  (in_b_row),
    .arr_clr   (arr_clr),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .e_out     (e_out),
    .f_out     (f_out),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  assign act_vec = {arr_clr, busy, done, in_ready, a_out, b_out, c_out, d_out, e_out, f_out};

  function automatic logic [W-1:0] pack(input logic clr, input logic bsy, input logic dn,
                                        input logic rdy, input logic [DW-1:0] o [6]);
    return {clr, bsy, dn, rdy, o[0], o[1], o[2], o[3], o[4], o[5]};
  endfunction

  // Reference: cycle c of the busy window, from the skew rule on A and B.
  function automatic logic [W-1:0] exp_cycle(input int c, input mat_t a, input mat_t b);
    logic [DW-1:0] o [6];
    int t;
    for (int k = 0; k < 6; k++) o[k] = '0;
    if (c >= 1 && c <= 5) begin
      t = c - 1;
      for (int i = 0; i < 3; i++) if (t - i >= 0 && t - i < 3) o[i] = a[i][t-i];
      for (int j = 0; j < 3; j++) if (t - j >= 0 && t - j < 3) o[3+j] = b[t-j][j];
    end
    return pack(c == 0, 1'b1, c == WIN - 1, 1'b0, o);
  endfunction

  function automatic logic [W-1:0] idle_vec();
    logic [DW-1:0] o [6];
    for (int k = 0; k < 6; k++) o[k] = '0;
    return pack(1'b0, 1'b0, 1'b0, 1'b1, o);
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d", name, act, exp);
    end
  endtask

  // driver: presents beats per valid pattern (LSB first) until three are accepted
  task automatic drive_load(input mat_t a, input mat_t b, input logic [7:0] pat);
    int k = 0;
    int n = 0;
    logic v;
    while (k < 3) begin
      @(negedge clk);
      v = (n >= 8) ? 1'b1 : pat[n];
      n++;
      in_valid = v;
      if (v) begin
        for (int i = 0; i < 3; i++) begin
          in_a_col[i*DW +: DW] = a[i][k];
          in_b_row[i*DW +: DW] = b[k][i];
        end
      end else begin
        in_a_col = {$urandom, $urandom, $urandom};
        in_b_row = {$urandom, $urandom, $urandom};
      end
      check_val("load_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      if (v) k++;
    end
  endtask

  // scoreboard over the busy window plus the following idle cycle
  task automatic check_window(input mat_t a, input mat_t b, input logic hold, input string tag);
    logic [W-1:0] exp;
    for (int c = 0; c < WIN; c++) exp_q.push_back(exp_cycle(c, a, b));
    clr_seen = 1'b0;
    for (int c = 0; c < WIN; c++) begin
      @(negedge clk);
      in_valid = (c == WIN - 1) ? 1'b0 : hold;
      in_a_col = {$urandom, $urandom, $urandom};
      in_b_row = {$urandom, $urandom, $urandom};
      exp = exp_q.pop_front();
      check_vec($sformatf("%s_c%0d", tag, c), act_vec, exp);
      if (arr_clr) clr_seen = 1'b1;
      if (c >= 1 && c <= 5) begin
        log_op[c-1][0] = a_out; log_op[c-1][1] = b_out; log_op[c-1][2] = c_out;
        log_op[c-1][3] = d_out; log_op[c-1][4] = e_out; log_op[c-1][5] = f_out;
      end
    end
    @(negedge clk);
    check_vec({tag, "_idle"}, act_vec, idle_vec());
  endtask

  task automatic run_job(input job_t j, input string tag);
    drive_load(j.a, j.b, j.pat);
    check_window(j.a, j.b, j.hold, tag);
  endtask

  // PE(i,j) sees row i delayed j cycles and column j delayed i cycles.
  task automatic array_accumulate();
    int q;
    if (clr_seen) for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) acc[i][j] = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        for (int r = 0; r < 5; r++) begin
          q = r + j - i;
          if (q >= 0 && q < 5) acc[i][j] += longint'(log_op[r][i]) * longint'(log_op[q][3+j]);
        end
  endtask

  task automatic check_product(input mat_t a, input mat_t b, input string tag);
    longint p;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        p = 0;
        for (int k = 0; k < 3; k++) p += longint'(a[i][k]) * longint'(b[k][j]);
        check_val($sformatf("%s_out%0d", tag, i * 3 + j + 1), 64'(acc[i][j]), 64'(p));
      end
  endtask

  task automatic check_feed_table(input string tag);
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < 6; k++)
        check_val($sformatf("%s_t%0d_op%0d", tag, t, k), 64'(log_op[t][k]), 64'(feed_tbl[t].op[k]));
  endtask

  function automatic mat_t rand_mat(input int maxv);
    mat_t m;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) m[i][j] = $urandom_range(0, maxv);
    return m;
  endfunction

  initial begin
    mat_t ident, twos, m1, m2;
    job_t rj;
    logic [DW-1:0] rowsA [5][6];

    ident = '{'{32'd1, 32'd0, 32'd0}, '{32'd0, 32'd1, 32'd0}, '{32'd0, 32'd0, 32'd1}};
    twos  = '{'{32'd2, 32'd2, 32'd2}, '{32'd2, 32'd2, 32'd2}, '{32'd2, 32'd2, 32'd2}};
    jobs[0].a = '{'{32'd1, 32'd2, 32'd3}, '{32'd4, 32'd5, 32'd6}, '{32'd7, 32'd8, 32'd9}};
    jobs[0].b = ident; jobs[0].pat = 8'hFF; jobs[0].hold = 1'b0;
    jobs[1].a = jobs[0].a;
    jobs[1].b = ident; jobs[1].pat = 8'h29; jobs[1].hold = 1'b1;
    jobs[2].a = '{'{32'd4, 32'd5, 32'd2}, '{32'd3, 32'd6, 32'd3}, '{32'd6, 32'd7, 32'd6}};
    jobs[2].b = ident; jobs[2].pat = 8'hFF; jobs[2].hold = 1'b0;
    jobs[3].a = '{'{32'd9, 32'd1, 32'd5}, '{32'd2, 32'd8, 32'd3}, '{32'd7, 32'd4, 32'd6}};
    jobs[3].b = '{'{32'd1, 32'd2, 32'd0}, '{32'd0, 32'd1, 32'd3}, '{32'd2, 32'd0, 32'd1}};
    jobs[3].pat = 8'h5A; jobs[3].hold = 1'b1;

    // FEED stream for A=1..9, B=I: {a,b,c,d,e,f} per t
    rowsA = '{'{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0},
              '{32'd2, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0},
              '{32'd3, 32'd5, 32'd7, 32'd0, 32'd1, 32'd0},
              '{32'd0, 32'd6, 32'd8, 32'd0, 32'd0, 32'd0},
              '{32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd1}};
    for (int t = 0; t < 5; t++) for (int k = 0; k < 6; k++) feed_tbl[t].op[k] = rowsA[t][k];
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) acc[i][j] = 0;

    // reset with in_valid pulses that must not be stored
    rst = 1'b1; in_valid = 1'b0; in_a_col = '0; in_b_row = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_a_col = {$urandom, $urandom, $urandom};
      in_b_row = {$urandom, $urandom, $urandom};
      check_vec("rst_hold", act_vec, idle_vec());
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_vec("idle", act_vec, idle_vec());
      check_val("idle_state", 64'(dbg_state), 64'(ST_LOAD));
    end

    // back-to-back load, then gapped load with in_valid held while busy
    run_job(jobs[0], "s2");
    check_feed_table("s2tbl");
    run_job(jobs[1], "s3");
    check_feed_table("s3tbl");

    // reset during FEED t=2
    m1 = rand_mat(1000);
    drive_load(m1, m1, 8'hFF);
    for (int c = 0; c < WIN; c++) exp_q.push_back(exp_cycle(c, m1, m1));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check_vec($sformatf("s4_c%0d", c), act_vec, exp_q.pop_front());
    end
    exp_q.delete();
    rst = 1'b1;
    #1;
    check_vec("s4_rst", act_vec, idle_vec());
    check_val("s4_state", 64'(dbg_state), 64'(ST_LOAD));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_vec("s4_idle", act_vec, idle_vec());
    rj.a = twos; rj.b = twos; rj.pat = 8'hFF; rj.hold = 1'b0;
    run_job(rj, "s4new");

    // two consecutive jobs through the bench-side array
    run_job(jobs[2], "s5a");
    array_accumulate();
    check_val("s5a_clr", 64'(clr_seen), 64'd1);
    check_product(jobs[2].a, jobs[2].b, "s5a");
    run_job(jobs[3], "s5b");
    array_accumulate();
    check_product(jobs[3].a, jobs[3].b, "s5b");

    // random jobs
    for (int r = 0; r < 6; r++) begin
      m1 = rand_mat(32'hFFFF);
      m2 = rand_mat(32'hFFFF);
      rj.a = m1; rj.b = m2;
      rj.pat = 8'($urandom_range(0, 255));
      rj.hold = 1'($urandom_range(0, 1));
      run_job(rj, $sformatf("rnd%0d", r));
      array_accumulate();
      check_product(m1, m2, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
